// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART frame transmitter: parity modes and FSM state encoding.
package uart_tx_frame_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO: rd_data presents the oldest entry whenever !empty.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   // Flags come straight from the registered count, so a pop while full frees a slot next cycle.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: buffers producer bytes in a FIFO and serialises them LSB first on line_tx,
// with configurable data width, parity and stop bits, sending queued frames back to back.
module uart_tx_frame
   import uart_tx_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2500,
   parameter int DATA_W       = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              line_tx,
   output logic              busy
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATA_W + 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_frame: DATA_W must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
   end

   function automatic logic parity_of(input logic [DATA_W-1:0] d);
      if (PARITY == PAR_ODD) begin
         return ~(^d);
      end
      return ^d;
   endfunction

   tx_state_e         state_q;
   tx_state_e         state_d;
   logic [BW-1:0]     baud_q;
   logic [NW-1:0]     bit_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_q;
   logic              line_d;
   logic              tick;
   logic              pop;
   logic              bit_clr;
   logic              bit_inc;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tx_valid && tx_ready),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign tx_ready = !fifo_full;
   assign busy     = (state_q != S_IDLE) || !fifo_empty;
   assign tick     = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      bit_clr = 1'b0;
      bit_inc = 1'b0;
      line_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            line_d = 1'b0;
            if (tick) begin
               bit_clr = 1'b1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (tick) begin
               if (bit_q == NW'(DATA_W - 1)) begin
                  bit_clr = 1'b1;
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         S_PARITY: begin
            line_d = par_q;
            if (tick) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            // bit_q counts stop bits here; the next frame starts without an idle bit.
            if (tick) begin
               if (bit_q == NW'(STOP_BITS - 1)) begin
                  bit_clr = 1'b1;
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // START is only entered from IDLE or on a tick, so the baud counter is zero on every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         line_tx <= 1'b1;
      end else begin
         state_q <= state_d;
         line_tx <= line_d;
         if (state_q == S_IDLE || tick) begin
            baud_q <= '0;
         end else begin
            baud_q <= baud_q + BW'(1);
         end
         if (bit_clr) begin
            bit_q <= '0;
         end else if (bit_inc) begin
            bit_q <= bit_q + NW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_q <= fifo_rd_data;
         par_q   <= parity_of(fifo_rd_data);
      end else if (state_q == S_DATA && tick) begin
         shift_q <= {1'b0, shift_q[DATA_W-1:1]};
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations at 4 clocks per bit, each with a UART line
// monitor that decodes frames and compares them against a queue filled at handshake time.
module tb_uart_tx_frame;

   localparam int CPB = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] vld   = '0;
   logic [7:0] d0 = '0, d1 = '0, d2 = '0;
   logic [6:0] d3 = '0;
   wire        l0, l1, l2, l3, r0, r1, r2, r3, b0, b1, b2, b3;
   wire  [3:0] lines = {l3, l2, l1, l0};
   wire  [3:0] rdys  = {r3, r2, r1, r0};
   wire  [3:0] busys = {b3, b2, b1, b0};

   int          checks   = 0;
   int          failures = 0;
   longint      cyc      = 0;
   logic [15:0] exp0[$], exp1[$], exp2[$], exp3[$];
   longint      st0[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_8n1 (.clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(vld[0]), .tx_ready(r0),
             .line_tx(l0), .busy(b0));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_8e1 (.clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(vld[1]), .tx_ready(r1),
             .line_tx(l1), .busy(b1));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_8o1 (.clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(vld[2]), .tx_ready(r2),
             .line_tx(l2), .busy(b2));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_W(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      u_7n2 (.clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(vld[3]), .tx_ready(r3),
             .line_tx(l3), .busy(b3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int nbits(input int k);
      return (k == 1 || k == 2) ? 11 : 10;
   endfunction

   function automatic void push_exp(input int k, input logic [15:0] fr);
      case (k)
         0:       exp0.push_back(fr);
         1:       exp1.push_back(fr);
         2:       exp2.push_back(fr);
         default: exp3.push_back(fr);
      endcase
   endfunction

   function automatic bit pop_exp(input int k, output logic [15:0] e);
      e = '0;
      case (k)
         0: if (exp0.size() != 0) begin e = exp0.pop_front(); return 1'b1; end
         1: if (exp1.size() != 0) begin e = exp1.pop_front(); return 1'b1; end
         2: if (exp2.size() != 0) begin e = exp2.pop_front(); return 1'b1; end
         default: if (exp3.size() != 0) begin e = exp3.pop_front(); return 1'b1; end
      endcase
      return 1'b0;
   endfunction

   // Waits for a start bit, then samples each bit at its centre; a reset during the frame voids it.
   task automatic capture(input int k, output logic [15:0] fr, output bit ok, output longint t0);
      int nb;
      nb = nbits(k);
      fr = '0;
      ok = 1'b1;
      @(negedge clk);
      while (lines[k] !== 1'b0 || !rst_n) @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < nb; i++) begin
         for (int c = 0; c < ((i == 0) ? 2 : CPB); c++) begin
            @(negedge clk);
            if (!rst_n) ok = 1'b0;
         end
         fr[i] = lines[k];
      end
   endtask

   task automatic judge(input int k, input logic [15:0] fr, input longint t0);
      logic [15:0] e;
      if (!pop_exp(k, e)) begin
         checks++;
         failures++;
         $display("FAIL frame%0d_unexpected actual=%0h required=none", k, fr);
      end else begin
         check($sformatf("frame%0d", k), {16'h0, fr}, {16'h0, e});
      end
      if (k == 0) st0.push_back(t0);
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_mon
      always begin
         logic [15:0] fr;
         bit          ok;
         longint      t0;
         capture(g, fr, ok, t0);
         if (ok) judge(g, fr, t0);
      end
   end

   task automatic push(input int k, input logic [8:0] d, input logic [15:0] fr, output int waited);
      @(negedge clk);
      case (k)
         0:       d0 = d[7:0];
         1:       d1 = d[7:0];
         2:       d2 = d[7:0];
         default: d3 = d[6:0];
      endcase
      vld[k] = 1'b1;
      waited = 0;
      while (!rdys[k] && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!rdys[k]) begin
         checks++;
         failures++;
         $display("FAIL push%0d_timeout actual=ready_low required=ready_high", k);
         vld[k] = 1'b0;
      end else begin
         @(posedge clk);
         push_exp(k, fr);
      end
   endtask

   // Single frame into an idle DUT: start-bit latency and busy duration counted from the pop edge.
   task automatic send_one(input int k, input logic [8:0] d, input logic [15:0] fr,
                           input int exp_len);
      int w;
      int cnt;
      push(k, d, fr, w);
      check($sformatf("ready_wait%0d", k), w, 0);
      @(negedge clk);
      vld[k] = 1'b0;
      @(negedge clk);
      check($sformatf("line_pre_start%0d", k), 32'(lines[k]), 1);
      cnt = 1;
      @(negedge clk);
      check($sformatf("line_start_lat%0d", k), 32'(lines[k]), 0);
      while (busys[k] && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      check($sformatf("busy_len%0d", k), cnt, exp_len);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w[7];
      int          cnt;
      int          lowcnt;
      int          busycnt;
      int          sent;
      int          guard;
      logic [7:0]  dv;
      logic [15:0] six_fr[6];

      repeat (3) @(negedge clk);
      check("reset_line", 32'(lines), 32'hF);
      check("reset_ready", 32'(rdys), 32'hF);
      check("reset_busy", 32'(busys), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_line", 32'(lines), 32'hF);

      // 8N1 'H': 0 | 0,0,0,1,0,0,1,0 | 1
      send_one(0, 9'h048, 16'h0290, 40);
      // even parity 'H' -> parity 0; odd parity '0' -> parity 1
      send_one(1, 9'h048, 16'h0490, 44);
      send_one(2, 9'h030, 16'h0660, 44);
      // 7 data bits, 2 stop: 0 | 1,0,1,0,1,0,1 | 1,1
      send_one(3, 9'h055, 16'h03AA, 40);

      // Six back-to-back bytes into a 4-deep FIFO with tx_valid held high
      six_fr = '{16'h0202, 16'h0204, 16'h0206, 16'h0208, 16'h020A, 16'h020C};
      st0.delete();
      for (int i = 1; i <= 6; i++) begin
         push(0, 9'(i), six_fr[i-1], w[i]);
      end
      @(negedge clk);
      vld[0] = 1'b0;
      for (int i = 1; i <= 5; i++) check($sformatf("burst_wait%0d", i), w[i], 0);
      check("burst_wait6", w[6], 37);
      cnt = 0;
      while (busys[0] && cnt < 5000) begin
         cnt++;
         @(negedge clk);
      end
      check("burst_drain", 32'(busys[0]), 0);
      check("burst_frames", st0.size(), 6);
      for (int i = 1; i < st0.size(); i++) begin
         check($sformatf("burst_gap%0d", i), 32'(st0[i] - st0[i-1]), 40);
      end

      // Reset in the middle of the second of three queued frames
      push(0, 9'h0A1, 16'h0342, w[0]);
      push(0, 9'h0B2, 16'h0364, w[0]);
      push(0, 9'h0C3, 16'h0386, w[0]);
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_line", 32'(lines[0]), 1);
      check("rst_ready", 32'(rdys[0]), 1);
      check("rst_busy", 32'(busys[0]), 0);
      check("rst_pending", exp0.size(), 2);
      exp0.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lowcnt  = 0;
      busycnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (!lines[0]) lowcnt++;
         if (busys[0]) busycnt++;
      end
      check("post_rst_line_low", lowcnt, 0);
      check("post_rst_busy", busycnt, 0);

      // tx_valid toggling every cycle with random data, 200 frames
      sent  = 0;
      guard = 0;
      while (sent < 200 && guard < 40000) begin
         @(negedge clk);
         guard++;
         vld[0] = ~vld[0];
         if (vld[0]) begin
            dv = 8'($urandom);
            d0 = dv;
            if (rdys[0]) begin
               push_exp(0, 16'({1'b1, dv, 1'b0}));
               sent++;
            end
         end
      end
      @(negedge clk);
      vld[0] = 1'b0;
      check("stream_sent", sent, 200);
      cnt = 0;
      while ((busys[0] || exp0.size() != 0) && cnt < 20000) begin
         cnt++;
         @(negedge clk);
      end
      check("stream_left", exp0.size(), 0);
      repeat (20) @(negedge clk);
      check("all_left", exp0.size() + exp1.size() + exp2.size() + exp3.size(), 0);
      check("final_line", 32'(lines), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
